// File: rtl/delay_tap_pkg.sv
// Shared types and helpers for the delay tap controller.
// Operating modes, gain constants and delay clamping.
package delay_tap_pkg;

  typedef enum logic [1:0] {
    FILL,
    TRACK,
    FADE,
    JUMP
  } state_e;

  localparam int GAIN_W = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  // A zero delay would read the word being written; treat it as one.
  function automatic logic [31:0] clamp_delay(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/simple_dp_ram.sv
// Single-clock RAM with one write port and one registered read port.
// Contents are never cleared.
module simple_dp_ram #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 15
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/delay_tap_controller.sv
// Circular-buffer delay line with click-free delay changes.
// Fades out, jumps the read pointer, then hands fade-in downstream.
module delay_tap_controller
  import delay_tap_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 15,
  parameter int SETTLE_TICKS = 64,
  parameter int FADE_STEP    = 2
) (
  input  logic                     clk_i,
  input  logic                     srst_n_i,
  input  logic                     sample_tick_i,
  input  logic signed [DWIDTH-1:0] data_i,
  input  logic        [AWIDTH-1:0] delay_i,
  output logic signed [DWIDTH-1:0] data_o,
  output logic                     data_valid_o,
  output logic                     unmute_trigger_o,
  output logic                     busy_o
);

  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int PW = DWIDTH + GAIN_W + 1;

  state_e state;

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_addr;
  logic [AWIDTH-1:0] delay_active;
  logic [AWIDTH-1:0] delay_pend;
  logic [AWIDTH-1:0] delay_req;
  logic [AWIDTH-1:0] fill_cnt;
  logic [SW-1:0]     settle_cnt;

  logic pend_vld;
  logic jump_arm;
  logic trig_pend;
  logic tick_d1;

  logic        [GAIN_W-1:0] gain;
  logic        [GAIN_W-1:0] gain_dec;
  logic signed [DWIDTH-1:0] rd_q;
  logic signed [PW-1:0]     prod;

  assign delay_req = AWIDTH'(clamp_delay(32'(delay_i)));
  assign rd_addr   = wr_ptr - delay_active;

  assign gain_dec = (gain > GAIN_W'(FADE_STEP))
                  ? gain - GAIN_W'(FADE_STEP)
                  : '0;

  assign prod = PW'(rd_q) * PW'($signed({1'b0, gain}));

  simple_dp_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (sample_tick_i),
    .wr_addr (wr_ptr),
    .wr_data (data_i),
    .rd_en   (sample_tick_i),
    .rd_addr (rd_addr),
    .rd_data (rd_q)
  );

  // Write pointer advances once per sample and wraps naturally.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr <= '0;
    end else if (sample_tick_i) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Scale the registered RAM word by the gain held one clk after the tick.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      tick_d1      <= 1'b0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
    end else begin
      tick_d1      <= sample_tick_i;
      data_valid_o <= tick_d1;
      if (tick_d1) data_o <= DWIDTH'(prod >>> 8);
    end
  end

  // Mode control: fill, track delay_i, fade out, jump, hand off fade-in.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state            <= FILL;
      busy_o           <= 1'b1;
      gain             <= '0;
      delay_active     <= delay_req;
      delay_pend       <= delay_req;
      fill_cnt         <= '0;
      settle_cnt       <= '0;
      pend_vld         <= 1'b0;
      jump_arm         <= 1'b0;
      trig_pend        <= 1'b0;
      unmute_trigger_o <= 1'b0;
    end else begin
      // The trigger waits for a clk that carries no output strobe.
      unmute_trigger_o <= 1'b0;
      if (trig_pend && !tick_d1) begin
        unmute_trigger_o <= 1'b1;
        trig_pend        <= 1'b0;
      end

      unique case (state)
        FILL: begin
          if (fill_cnt == delay_active) begin
            state     <= TRACK;
            busy_o    <= 1'b0;
            gain      <= GAIN_UNITY;
            trig_pend <= 1'b1;
          end else if (sample_tick_i) begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end

        TRACK: begin
          if (sample_tick_i) begin
            if (pend_vld && delay_req == delay_active) begin
              pend_vld <= 1'b0;
            end else if (pend_vld && delay_req == delay_pend) begin
              settle_cnt <= settle_cnt + 1'b1;
              if (settle_cnt == SW'(SETTLE_TICKS - 1)) begin
                state    <= FADE;
                busy_o   <= 1'b1;
                pend_vld <= 1'b0;
              end
            end else if (delay_req != delay_active) begin
              pend_vld   <= 1'b1;
              delay_pend <= delay_req;
              settle_cnt <= '0;
            end
          end
        end

        FADE: begin
          if (sample_tick_i) begin
            delay_pend <= delay_req;
            gain       <= gain_dec;
            if (gain_dec == '0) state <= JUMP;
          end
        end

        JUMP: begin
          if (jump_arm) begin
            jump_arm  <= 1'b0;
            state     <= TRACK;
            busy_o    <= 1'b0;
            gain      <= GAIN_UNITY;
            trig_pend <= 1'b1;
          end else if (sample_tick_i) begin
            delay_active <= delay_pend;
            jump_arm     <= 1'b1;
          end
        end

        default: begin
          state  <= FILL;
          busy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_tap_controller.sv
// Scoreboard bench for delay_tap_controller.
// Directed phases with hand-derived gain/delay schedules.
module tb_delay_tap_controller;

  localparam int DW = 16;
  localparam int AW = 15;

  logic                 clk_i = 1'b0;
  logic                 srst_n_i = 1'b0;
  logic                 sample_tick_i = 1'b0;
  logic signed [DW-1:0] data_i = '0;
  logic        [AW-1:0] delay_i = '0;
  logic signed [DW-1:0] data_o;
  logic                 data_valid_o;
  logic                 unmute_trigger_o;
  logic                 busy_o;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] expq[$];
  logic signed [DW-1:0] hist [0:65535];
  logic signed [DW-1:0] e;

  int n = 0;
  int exp_g = 0;
  int exp_d = 1;
  int unm_cnt = 0;
  int c = 0;
  logic unm_prev = 1'b0;

  always #5 clk_i = ~clk_i;

  delay_tap_controller dut (
    .clk_i            (clk_i),
    .srst_n_i         (srst_n_i),
    .sample_tick_i    (sample_tick_i),
    .data_i           (data_i),
    .delay_i          (delay_i),
    .data_o           (data_o),
    .data_valid_o     (data_valid_o),
    .unmute_trigger_o (unmute_trigger_o),
    .busy_o           (busy_o)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic signed [DW-1:0] pat(input int k);
    return 16'(k * 37 - 3000);
  endfunction

  // Monitor: pop and compare on every output strobe.
  always @(negedge clk_i) begin
    if (srst_n_i && data_valid_o) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got %0d, expected none", data_o);
      end else begin
        e = expq.pop_front();
        check("data_o", int'(data_o), int'(e));
      end
    end
    if (unmute_trigger_o) begin
      unm_cnt++;
      check("unmute_vs_valid", int'(data_valid_o), 0);
      check("unmute_width", int'(unm_prev), 0);
    end
    unm_prev = unmute_trigger_o;
  end

  task automatic do_tick(input logic signed [DW-1:0] d,
                         input logic [AW-1:0] dl);
    int x;
    @(posedge clk_i);
    #1;
    sample_tick_i = 1'b1;
    data_i  = d;
    delay_i = dl;
    hist[n] = d;
    if (exp_g == 0) x = 0;
    else x = (int'(hist[n - exp_d]) * exp_g) >>> 8;
    expq.push_back(16'(x));
    n++;
    @(posedge clk_i);
    #1;
    sample_tick_i = 1'b0;
  endtask

  task automatic do_reset(input logic [AW-1:0] dl);
    repeat (4) @(posedge clk_i);
    #1;
    check("queue_drained", expq.size(), 0);
    srst_n_i = 1'b0;
    sample_tick_i = 1'b0;
    delay_i = dl;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", int'(busy_o), 1);
    check("rst_valid", int'(data_valid_o), 0);
    check("rst_unmute", int'(unmute_trigger_o), 0);
    check("rst_data", int'(data_o), 0);
    srst_n_i = 1'b1;
    n = 0;
    exp_g = 0;
    exp_d = (dl == 0) ? 1 : int'(dl);
    expq.delete();
    unm_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // Fill with delay 4 and a ramp 1,2,3...
    do_reset(15'd4);
    repeat (4) do_tick(16'(n + 1), 15'd4);
    exp_g = 256;
    repeat (16) do_tick(16'(n + 1), 15'd4);
    check("fill4_unmute", unm_cnt, 1);

    // Zero delay acts as one sample.
    do_reset(15'd0);
    do_tick(pat(n), 15'd0);
    exp_g = 256;
    repeat (10) do_tick(pat(n), 15'd0);
    check("d0_unmute", unm_cnt, 1);

    // Delay 100, toggling 100/101 never settles.
    do_reset(15'd100);
    repeat (100) do_tick(16'sd1000, 15'd100);
    exp_g = 256;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 10; k++) begin
        do_tick(16'sd1000, (i % 2 == 0) ? 15'd101 : 15'd100);
        check("toggle_busy", int'(busy_o), 0);
      end
    end
    check("d100_unmute", unm_cnt, 1);
    unm_cnt = 0;

    // Step to 200: settle, fade 992,984,...,0, jump.
    c = n;
    for (int i = 0; i < 65; i++) begin
      do_tick(16'sd1000, 15'd200);
      if (i == 63) check("settle_busy_low", int'(busy_o), 0);
    end
    check("fade_busy", int'(busy_o), 1);
    for (int j = 0; j < 128; j++) begin
      exp_g = 254 - 2 * j;
      do_tick((n < c + 93) ? 16'sd1000 : pat(n), 15'd200);
    end
    check("jump_busy", int'(busy_o), 1);
    check("fade_no_unmute", unm_cnt, 0);
    exp_g = 0;
    do_tick(pat(n), 15'd200);
    exp_g = 256;
    exp_d = 200;
    repeat (120) do_tick(pat(n), 15'd200);
    check("d200_busy", int'(busy_o), 0);
    check("d200_unmute", unm_cnt, 1);
    unm_cnt = 0;

    // Retarget 250 -> 300 mid-fade; jump lands at 300.
    repeat (65) do_tick(pat(n), 15'd250);
    for (int j = 0; j < 128; j++) begin
      exp_g = 254 - 2 * j;
      do_tick(pat(n), (j < 10) ? 15'd250 : 15'd300);
    end
    exp_g = 0;
    do_tick(pat(n), 15'd300);
    exp_g = 256;
    exp_d = 300;
    repeat (40) do_tick(pat(n), 15'd300);
    check("d300_busy", int'(busy_o), 0);
    check("d300_unmute", unm_cnt, 1);
    unm_cnt = 0;

    // Reset in the middle of a fade goes back to FILL.
    repeat (65) do_tick(pat(n), 15'd310);
    for (int j = 0; j < 20; j++) begin
      exp_g = 254 - 2 * j;
      do_tick(pat(n), 15'd310);
    end
    check("midfade_busy", int'(busy_o), 1);
    check("midfade_unmute", unm_cnt, 0);
    do_reset(15'd8);
    repeat (8) do_tick(pat(n), 15'd8);
    exp_g = 256;
    repeat (12) do_tick(pat(n), 15'd8);
    check("refill_unmute", unm_cnt, 1);

    // Maximum delay across a write-pointer wrap.
    do_reset(15'h7fff);
    repeat (32767) do_tick(pat(n), 15'h7fff);
    exp_g = 256;
    repeat (20) do_tick(pat(n), 15'h7fff);
    check("wrap_unmute", unm_cnt, 1);

    repeat (4) @(posedge clk_i);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
